// File: rtl/instr_loader_pkg.sv
// instr_pkg: instruction word layout, loader states and ALU command limit shared by the loader files.
package instr_pkg;
    localparam int OP_W = 12;
    localparam int CMD_W = 4;
    localparam int WORD_W = 32;
    localparam logic [CMD_W-1:0] CMD_MAX = 4'd6;
    typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
    // Word layout: op1 [31:20], op2 [19:8], cmd [7:4], zero nibble [3:0]
    function automatic logic [WORD_W-1:0] pack_word(input logic [OP_W-1:0] op1, input logic [OP_W-1:0] op2,
                                                    input logic [CMD_W-1:0] cmd);
        return {op1, op2, cmd, 4'b0000};
    endfunction
endpackage

// File: rtl/instr_loader_if.sv
// instr_loader_if: valid/ready write channel carrying one ALU operation (op1, op2, cmd).
interface instr_loader_if;
    import instr_pkg::*;
    logic wr_valid;
    logic wr_ready;
    logic [OP_W-1:0] wr_op1;
    logic [OP_W-1:0] wr_op2;
    logic [CMD_W-1:0] wr_cmd;
    modport master (output wr_valid, wr_op1, wr_op2, wr_cmd, input wr_ready);
    modport slave (input wr_valid, wr_op1, wr_op2, wr_cmd, output wr_ready);
endinterface

// File: rtl/instr_loader_mem.sv
// instr_mem: DEPTH x 32 synchronous RAM, one write port and one registered read port with sync clear.
module instr_mem
    import instr_pkg::*;
#(
    parameter int DEPTH = 100,
    parameter int IW = 7
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [IW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end
    // Only the read register clears; stored words survive reset
    always_ff @(posedge clk) begin
        if (clr) rdata <= '0;
        else if (re) rdata <= r_mem[raddr];
    end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: packs ALU operations into 32-bit words, stores them, and plays them back one per enable.
// Optional CMD_CHECK_EN: consume but drop writes with cmd > CMD_MAX and raise sticky rej.
module instr_loader
    import instr_pkg::*;
#(
    parameter int DEPTH = 100,
    parameter int AW = 8,
    parameter int LOOP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    instr_loader_if.slave     wr,
    input  logic              start,
    input  logic              enable,
    output logic [WORD_W-1:0] data,
    output logic              data_valid,
    output logic [AW-1:0]     count,
    output logic              full,
    output logic              done,
    output logic              rej
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    state_t r_state, w_state_nxt;
    logic [AW:0] r_count;
    logic [IW-1:0] r_wr_ptr, r_rd_ptr;
    logic r_data_valid;
    logic w_clr, w_acc, w_store, w_go, w_re, w_last;
    assign w_clr = rst || clr;
    // One spare count bit so full is reachable even when DEPTH == 2**AW
    assign full = r_count == (AW+1)'(DEPTH);
    assign wr.wr_ready = (r_state == LOAD) && !full;
    assign w_acc = wr.wr_valid && wr.wr_ready;
`ifdef CMD_CHECK_EN
    logic r_rej;
    assign w_store = w_acc && (wr.wr_cmd <= CMD_MAX);
    assign rej = r_rej;
    always_ff @(posedge clk) begin
        if (w_clr) r_rej <= 1'b0;
        else if (w_acc && !w_store) r_rej <= 1'b1;
    end
`else
    assign w_store = w_acc;
    assign rej = 1'b0;
`endif
    assign w_go = start && ((r_state != LOAD) || (r_count != '0) || w_store);
    assign w_re = (r_state == RUN) && enable && !start;
    assign w_last = r_rd_ptr == IW'(r_count - 1'b1);
    assign done = r_state == DONE;
    assign data_valid = r_data_valid;
    assign count = r_count[AW-1:0];
    always_ff @(posedge clk) begin
        if (w_clr) r_state <= LOAD;
        else r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = w_go ? RUN : (w_re && w_last && LOOP == 0) ? DONE : r_state;
    end
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_count <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_re;
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count <= r_count + 1'b1;
            end
            if (w_go) r_rd_ptr <= '0;
            else if (w_re) r_rd_ptr <= w_last ? '0 : r_rd_ptr + 1'b1;
        end
    end
    instr_mem #(.DEPTH(DEPTH), .IW(IW)) u_mem (
        .clk   (clk),
        .clr   (w_clr),
        .we    (w_store),
        .waddr (r_wr_ptr),
        .wdata (pack_word(wr.wr_op1, wr.wr_op2, wr.wr_cmd)),
        .re    (w_re),
        .raddr (r_rd_ptr),
        .rdata (data)
    );
endmodule
